regfile_dump: RTL and testbench

REGFILE_DUMP -- requirements
Module: regfile_dump

---
 rtl/regfile_dump.sv | 124 ++++++++++++
 tb/tb_regfile_dump.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Streams a contiguous window of register-file entries out over a valid/ready port,
// one read per word, with abort and synchronous active-low reset.
module regfile_dump #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned REGISTER_BITS = 4,
  parameter int unsigned FIRST_ADDR    = 1,
  parameter int unsigned LAST_ADDR     = (1 << REGISTER_BITS) - 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  output logic [REGISTER_BITS-1:0] rdAddress,
  input  logic [WIDTH-1:0]         rdData,
  output logic [WIDTH-1:0]         outData,
  output logic [REGISTER_BITS-1:0] outAddr,
  output logic                     outValid,
  input  logic                     outReady,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [REGISTER_BITS-1:0] FIRST = REGISTER_BITS'(FIRST_ADDR);
  localparam logic [REGISTER_BITS-1:0] LAST  = REGISTER_BITS'(LAST_ADDR);

  logic [1:0]               r_state;
  logic [REGISTER_BITS-1:0] r_addr;
  logic [WIDTH-1:0]         r_out_data;
  logic [REGISTER_BITS-1:0] r_out_addr;
  logic                     r_out_valid;
  logic                     r_done;

  logic [1:0]               w_state_nxt;
  logic [REGISTER_BITS-1:0] w_addr_nxt;
  logic [WIDTH-1:0]         w_out_data_nxt;
  logic [REGISTER_BITS-1:0] w_out_addr_nxt;
  logic                     w_out_valid_nxt;
  logic                     w_done_nxt;

  // State and output registers; reset is synchronous and beats every other input.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_addr  <= w_out_addr_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_out_data_nxt  = r_out_data;
    w_out_addr_nxt  = r_out_addr;
    w_out_valid_nxt = r_out_valid;
    w_done_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_out_valid_nxt = 1'b0;
        if (start && !abort) begin
          w_addr_nxt  = FIRST;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end else begin
          w_out_data_nxt  = rdData;
          w_out_addr_nxt  = r_addr;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_SEND;
        end
      end
      S_SEND: begin
        // A handshake coinciding with abort still transfers the word, but abort picks the next state.
        if (abort) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end else if (outReady) begin
          w_out_valid_nxt = 1'b0;
          if (r_addr == LAST) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_addr_nxt  = r_addr + REGISTER_BITS'(1);
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  assign rdAddress = (r_state == S_IDLE) ? '0 : r_addr;
  assign busy      = (r_state != S_IDLE);
  assign outData   = r_out_data;
  assign outAddr   = r_out_addr;
  assign outValid  = r_out_valid;
  assign done      = r_done;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed + randomized-ready bench for regfile_dump: a default instance and a
// single-register (15..15) instance, checked by an in-order word scoreboard.
module tb_regfile_dump;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        st  [2];
  logic        ab  [2];
  logic        rdy [2];
  logic [3:0]  rda [2];
  logic [15:0] rdd [2];
  logic [15:0] od  [2];
  logic [3:0]  oa  [2];
  logic        ov  [2];
  logic        bz  [2];
  logic        dn  [2];

  int compared   = 0;
  int mismatched = 0;
  int exp_addr [2];
  int first    [2];
  int words    [2];
  int dones    [2];

  always #5 clock = ~clock;

  // Register-file model: register K holds 0x1000 + K.
  assign rdd[0] = 16'h1000 + 16'(rda[0]);
  assign rdd[1] = 16'h1000 + 16'(rda[1]);

  regfile_dump dut0 (
    .clock(clock), .reset(rst_n), .start(st[0]), .abort(ab[0]),
    .rdAddress(rda[0]), .rdData(rdd[0]), .outData(od[0]), .outAddr(oa[0]),
    .outValid(ov[0]), .outReady(rdy[0]), .busy(bz[0]), .done(dn[0])
  );

  regfile_dump #(.FIRST_ADDR(15), .LAST_ADDR(15)) dut1 (
    .clock(clock), .reset(rst_n), .start(st[1]), .abort(ab[1]),
    .rdAddress(rda[1]), .rdData(rdd[1]), .outData(od[1]), .outAddr(oa[1]),
    .outValid(ov[1]), .outReady(rdy[1]), .busy(bz[1]), .done(dn[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic begin_dump(input int i);
    exp_addr[i] = first[i];
    words[i]    = 0;
    dones[i]    = 0;
  endtask

  // One clock: note handshakes/holds before the edge, then score the result after it.
  task automatic tick();
    bit          hs   [2];
    bit          hold [2];
    bit          fin  [2];
    logic [3:0]  a    [2];
    logic [15:0] d    [2];
    for (int i = 0; i < 2; i++) begin
      hs[i]   = (ov[i] === 1'b1) && (rdy[i] === 1'b1) && (rst_n === 1'b1);
      hold[i] = (ov[i] === 1'b1) && (rdy[i] === 1'b0) && (rst_n === 1'b1) && (ab[i] === 1'b0);
      fin[i]  = hs[i] && (oa[i] == 4'd15) && (ab[i] === 1'b0);
      a[i]    = oa[i];
      d[i]    = od[i];
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (hs[i]) begin
        chk($sformatf("word_addr%0d", i), 32'(a[i]), 32'(exp_addr[i]));
        chk($sformatf("word_data%0d", i), 32'(d[i]), 32'h1000 + 32'(exp_addr[i]));
        exp_addr[i]++;
        words[i]++;
      end
      if (hold[i]) begin
        chk($sformatf("hold_valid%0d", i), 32'(ov[i]), 32'd1);
        chk($sformatf("hold_addr%0d", i), 32'(oa[i]), 32'(a[i]));
        chk($sformatf("hold_data%0d", i), 32'(od[i]), 32'(d[i]));
      end
      chk($sformatf("done%0d", i), 32'(dn[i]), 32'(fin[i]));
      if (dn[i] === 1'b1) dones[i]++;
    end
  endtask

  task automatic run_until_done(input int i, input int budget, input bit rand_rdy, output int n);
    n = 0;
    while (dn[i] !== 1'b1 && n < budget) begin
      if (rand_rdy) rdy[i] = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk($sformatf("done_within_budget%0d", i), 32'(n < budget), 32'd1);
  endtask

  task automatic run_to_addr(input int i, input logic [3:0] addr);
    int n = 0;
    while (!(ov[i] === 1'b1 && oa[i] == addr) && n < 200) begin
      tick();
      n++;
    end
    chk($sformatf("reached_addr%0d", i), 32'(n < 200), 32'd1);
  endtask

  initial begin
    int n;
    int stall;
    first[0] = 1;
    first[1] = 15;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; ab[i] = 1'b0; rdy[i] = 1'b0;
      begin_dump(i);
    end

    // Reset state.
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", 32'(ov[i]), 32'd0);
      chk("rst_data", 32'(od[i]), 32'd0);
      chk("rst_addr", 32'(oa[i]), 32'd0);
      chk("rst_busy", 32'(bz[i]), 32'd0);
      chk("rst_rdaddr", 32'(rda[i]), 32'd0);
    end

    // Full dump with outReady high: one word per two cycles.
    begin_dump(0);
    st[0] = 1'b1; rdy[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    chk("busy_after_start", 32'(bz[0]), 32'd1);
    run_until_done(0, 200, 1'b0, n);
    chk("full_rate_cycles", 32'(n), 32'd30);
    tick();
    chk("t1_words", 32'(words[0]), 32'd15);
    chk("t1_dones", 32'(dones[0]), 32'd1);
    chk("t1_idle", 32'(bz[0]), 32'd0);

    // Random backpressure plus a 5-cycle stall on address 7.
    begin_dump(0);
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    stall = 0;
    n = 0;
    while (dn[0] !== 1'b1 && n < 600) begin
      if (ov[0] === 1'b1 && oa[0] == 4'd7 && stall == 0) begin
        rdy[0] = 1'b0;
        repeat (5) tick();
        stall = 1;
        chk("stall_addr7", 32'(oa[0]), 32'd7);
        chk("stall_data7", 32'(od[0]), 32'h1007);
      end
      rdy[0] = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("t2_budget", 32'(n < 600), 32'd1);
    tick();
    chk("t2_words", 32'(words[0]), 32'd15);
    chk("t2_dones", 32'(dones[0]), 32'd1);

    // Abort in SEND at address 7 with outReady low, then restart from address 1.
    begin_dump(0);
    st[0] = 1'b1; rdy[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    run_to_addr(0, 4'd7);
    rdy[0] = 1'b0; ab[0] = 1'b1;
    tick();
    ab[0] = 1'b0;
    chk("abort_valid", 32'(ov[0]), 32'd0);
    chk("abort_busy", 32'(bz[0]), 32'd0);
    chk("abort_words", 32'(words[0]), 32'd6);
    chk("abort_dones", 32'(dones[0]), 32'd0);
    begin_dump(0);
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    run_until_done(0, 600, 1'b1, n);
    tick();
    chk("restart_words", 32'(words[0]), 32'd15);
    chk("restart_dones", 32'(dones[0]), 32'd1);

    // Reset in SEND at address 4, then a dump with start held high throughout.
    begin_dump(0);
    st[0] = 1'b1; rdy[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    run_to_addr(0, 4'd4);
    rdy[0] = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_valid", 32'(ov[0]), 32'd0);
    chk("midrst_data", 32'(od[0]), 32'd0);
    chk("midrst_addr", 32'(oa[0]), 32'd0);
    chk("midrst_busy", 32'(bz[0]), 32'd0);
    chk("midrst_rdaddr", 32'(rda[0]), 32'd0);
    chk("midrst_dones", 32'(dones[0]), 32'd0);
    begin_dump(0);
    st[0] = 1'b1;
    run_until_done(0, 600, 1'b1, n);
    st[0] = 1'b0;
    tick();
    chk("held_start_idle", 32'(bz[0]), 32'd0);
    chk("held_start_words", 32'(words[0]), 32'd15);
    chk("held_start_dones", 32'(dones[0]), 32'd1);

    // Single-register window 15..15: one word, no wrap to register 0.
    begin_dump(1);
    st[1] = 1'b1; rdy[1] = 1'b1;
    tick();
    st[1] = 1'b0;
    run_until_done(1, 50, 1'b0, n);
    tick();
    tick();
    chk("single_words", 32'(words[1]), 32'd1);
    chk("single_dones", 32'(dones[1]), 32'd1);
    chk("single_idle", 32'(bz[1]), 32'd0);

    // Abort together with a handshake: word accepted, no done.
    begin_dump(1);
    st[1] = 1'b1; rdy[1] = 1'b0;
    tick();
    st[1] = 1'b0;
    run_to_addr(1, 4'd15);
    rdy[1] = 1'b1; ab[1] = 1'b1;
    tick();
    ab[1] = 1'b0;
    tick();
    chk("abort_hs_words", 32'(words[1]), 32'd1);
    chk("abort_hs_dones", 32'(dones[1]), 32'd0);
    chk("abort_hs_busy", 32'(bz[1]), 32'd0);
    chk("abort_hs_valid", 32'(ov[1]), 32'd0);

    // Start and abort together in IDLE: stays idle.
    st[0] = 1'b1; ab[0] = 1'b1;
    tick();
    chk("start_abort_idle", 32'(bz[0]), 32'd0);
    st[0] = 1'b0; ab[0] = 1'b0;
    tick();
    chk("start_abort_still_idle", 32'(bz[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
